// File: rtl/cp_l2mem_dma_client.sv
// Per-coprocessor DMA client for the shared L2 data memory arbiter.
// Copies a block of words between the local L1 DMEM and L2 in either
// direction, holding the arbiter slot (trq/tack) for the whole burst.
//
// Command handshake: a command is accepted on any rising clock edge where
// cmd_valid and cmd_ready are both high. cmd_ready is high only in IDLE.
// The command fields are sampled on that edge only. cmd_valid seen in any
// other state is ignored, and the latched command is left untouched.
//
// Outputs toward the memories are decoded combinationally from registered
// state, so an address presented in cycle t returns read data in cycle
// t + latency. A valid token follows each issued read through a short
// pipeline, and the write beat fires on the cycle that token emerges.
module cp_l2mem_dma_client #(
   parameter int CP_D_WIDTH      = 72,
   parameter int DMEM_ADDR_WIDTH = 10,
   parameter int L1_ADDR_WIDTH   = 10,
   parameter int L2_RD_LAT       = 1,   // legal 1..2
   parameter int L1_RD_LAT       = 1    // legal 1..2
) (
   input  logic                       clock,
   input  logic                       nreset,
   // command interface
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_dir,
   input  logic [DMEM_ADDR_WIDTH-1:0] cmd_l2_addr,
   input  logic [L1_ADDR_WIDTH-1:0]   cmd_l1_addr,
   input  logic [DMEM_ADDR_WIDTH:0]   cmd_len,
   output logic                       busy,
   output logic                       done,
   // arbiter slot
   output logic                       trq,
   input  logic                       tack,
   output logic [DMEM_ADDR_WIDTH-1:0] l2_addr,
   output logic [CP_D_WIDTH-1:0]      l2_din,
   output logic                       l2_we,
   input  logic [CP_D_WIDTH-1:0]      l2_dout,
   // local L1 DMEM
   output logic [L1_ADDR_WIDTH-1:0]   l1_addr,
   output logic [CP_D_WIDTH-1:0]      l1_din,
   output logic                       l1_we,
   input  logic [CP_D_WIDTH-1:0]      l1_dout,
   // debug view of the controller state
   output logic [2:0]                 fsm_state
);

   localparam int AW = DMEM_ADDR_WIDTH;
   localparam int LW = L1_ADDR_WIDTH;
   localparam int CW = DMEM_ADDR_WIDTH + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   logic [2:0]    state, state_nxt;
   logic          dir_q;        // 0 = load (L2->L1), 1 = store (L1->L2)
   logic [AW-1:0] l2_base_q;
   logic [LW-1:0] l1_base_q;
   logic [CW-1:0] len_q;
   logic [CW-1:0] issue_cnt;    // reads issued so far (i)
   logic [CW-1:0] wr_cnt;       // writes completed so far (j)
   logic [1:0]    tok_q;        // read-valid pipeline, bit 0 is one cycle old

   logic accept;
   logic active;
   logic issuing;
   logic last_issue;
   logic tok_out;
   logic writing;
   logic last_write;

   assign accept     = cmd_valid & cmd_ready;
   assign active     = (state == S_REQ) || (state == S_RUN) || (state == S_DRAIN);
   // A read is issued whenever the slot is granted and words remain.
   assign issuing    = ((state == S_REQ) || (state == S_RUN)) && tack &&
                       (issue_cnt != len_q);
   assign last_issue = issuing && (issue_cnt == len_q - CW'(1));
   // Tap the token pipeline at the read latency of the source memory.
   assign tok_out    = dir_q ? ((L1_RD_LAT == 2) ? tok_q[1] : tok_q[0])
                             : ((L2_RD_LAT == 2) ? tok_q[1] : tok_q[0]);
   assign writing    = tok_out && ((state == S_RUN) || (state == S_DRAIN));
   assign last_write = writing && (wr_cnt == len_q - CW'(1));

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FIN);
   assign trq       = active;
   assign fsm_state = state;

   // Next-state decode for the burst controller.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = (cmd_len == '0) ? S_FIN : S_REQ;
            end
         end
         S_REQ: begin
            // The first word is issued in the same cycle the grant is seen.
            if (tack) begin
               state_nxt = last_issue ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            if (last_issue) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (last_write) begin
               state_nxt = S_FIN;
            end
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register; reset aborts any burst in progress.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Command latch, issue/write counters and the read-valid pipeline.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         dir_q     <= 1'b0;
         l2_base_q <= '0;
         l1_base_q <= '0;
         len_q     <= '0;
         issue_cnt <= '0;
         wr_cnt    <= '0;
         tok_q     <= '0;
      end else begin
         if (accept) begin
            dir_q     <= cmd_dir;
            l2_base_q <= cmd_l2_addr;
            l1_base_q <= cmd_l1_addr;
            len_q     <= cmd_len;
            issue_cnt <= '0;
            wr_cnt    <= '0;
         end else begin
            if (issuing) begin
               issue_cnt <= issue_cnt + CW'(1);
            end
            if (writing) begin
               wr_cnt <= wr_cnt + CW'(1);
            end
         end
         tok_q <= {tok_q[0], issuing};
      end
   end

   // Memory-side address, data and write-enable decode. Everything is zero
   // outside an active burst so no stray enable reaches the shared L2 port.
   always_comb begin
      l2_addr = '0;
      l2_din  = '0;
      l2_we   = 1'b0;
      l1_addr = '0;
      l1_din  = '0;
      l1_we   = 1'b0;
      if (active) begin
         if (!dir_q) begin
            // load: read L2 at i, write L1 at j
            l2_addr = l2_base_q + AW'(issue_cnt);
            l1_addr = l1_base_q + LW'(wr_cnt);
            l1_we   = writing;
            l1_din  = writing ? l2_dout : '0;
         end else begin
            // store: read L1 at i, write L2 at j
            l1_addr = l1_base_q + LW'(issue_cnt);
            l2_addr = l2_base_q + AW'(wr_cnt);
            l2_we   = writing;
            l2_din  = writing ? l1_dout : '0;
         end
      end
   end

endmodule

// File: tb/tb_cp_l2mem_dma_client.sv
// Directed bench for cp_l2mem_dma_client: behavioural L1/L2 memories with
// one-cycle read latency, a registered arbiter grant, and activity counters
// sampled on the falling edge.
module tb_cp_l2mem_dma_client;

   localparam int DW = 72;
   localparam int AW = 10;
   localparam int LW = 10;

   logic          clock = 1'b0;
   logic          nreset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_dir;
   logic [AW-1:0] cmd_l2_addr;
   logic [LW-1:0] cmd_l1_addr;
   logic [AW:0]   cmd_len;
   logic          busy;
   logic          done;
   logic          trq;
   logic          tack = 1'b0;
   logic [AW-1:0] l2_addr;
   logic [DW-1:0] l2_din;
   logic          l2_we;
   logic [DW-1:0] l2_dout = '0;
   logic [LW-1:0] l1_addr;
   logic [DW-1:0] l1_din;
   logic          l1_we;
   logic [DW-1:0] l1_dout = '0;
   logic [2:0]    fsm_state;

   // bench-side memories and backdoor preload port
   logic [DW-1:0] l2_mem [0:1023];
   logic [DW-1:0] l1_mem [0:1023];
   logic          bd_l2_we = 1'b0;
   logic          bd_l1_we = 1'b0;
   logic [9:0]    bd_addr  = '0;
   logic [DW-1:0] bd_data  = '0;
   logic          grant_en = 1'b1;

   int checks = 0;
   int errors = 0;

   // activity counters
   int trq_cnt     = 0;
   int l1_we_cnt   = 0;
   int l2_we_cnt   = 0;
   int done_cnt    = 0;
   int we_no_tack  = 0;
   int l1_run      = 0;
   int l1_last_run = 0;
   int low_run     = 0;
   int last_gap    = 0;
   logic trq_prev  = 1'b0;

   cp_l2mem_dma_client dut (
      .clock       (clock),
      .nreset      (nreset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_dir     (cmd_dir),
      .cmd_l2_addr (cmd_l2_addr),
      .cmd_l1_addr (cmd_l1_addr),
      .cmd_len     (cmd_len),
      .busy        (busy),
      .done        (done),
      .trq         (trq),
      .tack        (tack),
      .l2_addr     (l2_addr),
      .l2_din      (l2_din),
      .l2_we       (l2_we),
      .l2_dout     (l2_dout),
      .l1_addr     (l1_addr),
      .l1_din      (l1_din),
      .l1_we       (l1_we),
      .l1_dout     (l1_dout),
      .fsm_state   (fsm_state)
   );

   // clock
   always #5 clock = ~clock;

   // memories (1-cycle read latency) and a registered arbiter grant
   always @(posedge clock) begin
      if (bd_l2_we) l2_mem[bd_addr] <= bd_data;
      else if (l2_we) l2_mem[l2_addr] <= l2_din;
      if (bd_l1_we) l1_mem[bd_addr] <= bd_data;
      else if (l1_we) l1_mem[l1_addr] <= l1_din;
      l2_dout <= l2_mem[l2_addr];
      l1_dout <= l1_mem[l1_addr];
      tack    <= trq & grant_en;
   end

   // activity monitor
   always @(negedge clock) begin
      if (trq)   trq_cnt   <= trq_cnt + 1;
      if (l1_we) l1_we_cnt <= l1_we_cnt + 1;
      if (l2_we) l2_we_cnt <= l2_we_cnt + 1;
      if (done)  done_cnt  <= done_cnt + 1;
      if (l2_we && !tack) we_no_tack <= we_no_tack + 1;
      if (l1_we) l1_run <= l1_run + 1;
      else if (l1_run != 0) begin
         l1_last_run <= l1_run;
         l1_run      <= 0;
      end
      if (trq) begin
         if (!trq_prev) last_gap <= low_run;
         low_run <= 0;
      end else begin
         low_run <= low_run + 1;
      end
      trq_prev <= trq;
   end

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] pat(input logic [7:0] tag, input int k);
      logic [7:0] t;
      t = tag + 8'(k);
      return {t, 64'h0123_4567_89AB_CDEF};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic preload_l2(input logic [9:0] a, input logic [DW-1:0] d);
      @(negedge clock);
      bd_addr = a; bd_data = d; bd_l2_we = 1'b1;
      @(negedge clock);
      bd_l2_we = 1'b0;
   endtask

   task automatic preload_l1(input logic [9:0] a, input logic [DW-1:0] d);
      @(negedge clock);
      bd_addr = a; bd_data = d; bd_l1_we = 1'b1;
      @(negedge clock);
      bd_l1_we = 1'b0;
   endtask

   // Returns on the falling edge of the first cycle after acceptance.
   task automatic issue_cmd(input logic dir, input logic [AW-1:0] l2a,
                            input logic [LW-1:0] l1a, input logic [AW:0] len);
      int n;
      @(negedge clock);
      cmd_dir = dir; cmd_l2_addr = l2a; cmd_l1_addr = l1a; cmd_len = len;
      cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL issue_cmd: cmd_ready stayed %b, required 1", cmd_ready);
      end
      @(posedge clock);
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < budget) begin
         @(negedge clock);
         cyc++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, cyc);
      end
   endtask

   task automatic settle();
      @(negedge clock);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      nreset = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0;
      cmd_l2_addr = '0; cmd_l1_addr = '0; cmd_len = '0;
      @(negedge clock);
      checks += 11;
      if (trq !== 1'b0)       begin errors++; $display("FAIL reset_trq: got %b, required 0", trq); end
      if (l2_we !== 1'b0)     begin errors++; $display("FAIL reset_l2_we: got %b, required 0", l2_we); end
      if (l1_we !== 1'b0)     begin errors++; $display("FAIL reset_l1_we: got %b, required 0", l1_we); end
      if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
      if (l2_addr !== '0)     begin errors++; $display("FAIL reset_l2_addr: got %h, required 0", l2_addr); end
      if (l1_addr !== '0)     begin errors++; $display("FAIL reset_l1_addr: got %h, required 0", l1_addr); end
      if (l2_din !== '0)      begin errors++; $display("FAIL reset_l2_din: got %h, required 0", l2_din); end
      if (l1_din !== '0)      begin errors++; $display("FAIL reset_l1_din: got %h, required 0", l1_din); end
      if (fsm_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", fsm_state); end
      @(negedge clock);
      nreset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_load();
      int t0, w0, s0, d0, cyc;
      for (int k = 0; k < 4; k++) preload_l2(10'h010 + 10'(k), pat(8'hA0, k));
      settle();
      t0 = trq_cnt; w0 = l1_we_cnt; s0 = l2_we_cnt; d0 = done_cnt;
      issue_cmd(1'b0, 10'h010, 10'h020, 11'd4);
      wait_done(50, "load", cyc);
      checks++;
      if (cyc != 6) begin errors++; $display("FAIL load_latency: done after %0d cycles, required 6", cyc); end
      settle();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (l1_mem[10'h020 + 10'(k)] !== pat(8'hA0, k)) begin
            errors++;
            $display("FAIL load_data[%0d]: got %h, required %h", k, l1_mem[10'h020 + 10'(k)], pat(8'hA0, k));
         end
      end
      checks += 5;
      if (trq_cnt - t0 != 6)   begin errors++; $display("FAIL load_trq_cycles: got %0d, required 6", trq_cnt - t0); end
      if (l1_we_cnt - w0 != 4) begin errors++; $display("FAIL load_l1_we_cycles: got %0d, required 4", l1_we_cnt - w0); end
      if (l1_last_run != 4)    begin errors++; $display("FAIL load_l1_we_run: got %0d, required 4", l1_last_run); end
      if (l2_we_cnt - s0 != 0) begin errors++; $display("FAIL load_l2_we_cycles: got %0d, required 0", l2_we_cnt - s0); end
      if (done_cnt - d0 != 1)  begin errors++; $display("FAIL load_done_pulses: got %0d, required 1", done_cnt - d0); end
   endtask

   task automatic test_store_wrap();
      int s0, n0, w0, cyc;
      preload_l1(10'h3FE, pat(8'hB0, 0));
      preload_l1(10'h3FF, pat(8'hB0, 1));
      preload_l1(10'h000, pat(8'hB0, 2));
      settle();
      s0 = l2_we_cnt; n0 = we_no_tack; w0 = l1_we_cnt;
      issue_cmd(1'b1, 10'h100, 10'h3FE, 11'd3);
      wait_done(50, "store", cyc);
      settle();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (l2_mem[10'h100 + 10'(k)] !== pat(8'hB0, k)) begin
            errors++;
            $display("FAIL store_data[%0d]: got %h, required %h", k, l2_mem[10'h100 + 10'(k)], pat(8'hB0, k));
         end
      end
      checks += 3;
      if (l2_we_cnt - s0 != 3)  begin errors++; $display("FAIL store_l2_we_cycles: got %0d, required 3", l2_we_cnt - s0); end
      if (we_no_tack - n0 != 0) begin errors++; $display("FAIL store_we_without_tack: got %0d, required 0", we_no_tack - n0); end
      if (l1_we_cnt - w0 != 0)  begin errors++; $display("FAIL store_l1_we_cycles: got %0d, required 0", l1_we_cnt - w0); end
   endtask

   task automatic test_zero_len();
      int t0, w1, w2, d0;
      settle();
      t0 = trq_cnt; w1 = l1_we_cnt; w2 = l2_we_cnt; d0 = done_cnt;
      issue_cmd(1'b0, 10'h123, 10'h045, 11'd0);
      checks += 3;
      if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b, required 1", done); end
      if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b, required 1", busy); end
      if (trq !== 1'b0)  begin errors++; $display("FAIL zero_trq: got %b, required 0", trq); end
      @(negedge clock);
      checks += 2;
      if (done !== 1'b0)      begin errors++; $display("FAIL zero_done_width: got %b, required 0", done); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b, required 1", cmd_ready); end
      settle();
      checks += 3;
      if (trq_cnt - t0 != 0) begin errors++; $display("FAIL zero_trq_cycles: got %0d, required 0", trq_cnt - t0); end
      if ((l1_we_cnt - w1) + (l2_we_cnt - w2) != 0) begin
         errors++; $display("FAIL zero_writes: got %0d, required 0", (l1_we_cnt - w1) + (l2_we_cnt - w2));
      end
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d, required 1", done_cnt - d0); end
   endtask

   task automatic test_grant_wait();
      int bad, cyc, n0;
      preload_l1(10'h050, pat(8'hC0, 0));
      preload_l1(10'h051, pat(8'hC0, 1));
      settle();
      n0 = we_no_tack;
      grant_en = 1'b0;
      issue_cmd(1'b1, 10'h200, 10'h050, 11'd2);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (trq !== 1'b1 || l2_we !== 1'b0 || l2_addr !== 10'h200 || busy !== 1'b1) bad++;
         @(negedge clock);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL wait_hold: %0d bad cycles, required 0", bad); end
      grant_en = 1'b1;
      wait_done(20, "wait", cyc);
      settle();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (l2_mem[10'h200 + 10'(k)] !== pat(8'hC0, k)) begin
            errors++;
            $display("FAIL wait_data[%0d]: got %h, required %h", k, l2_mem[10'h200 + 10'(k)], pat(8'hC0, k));
         end
      end
      checks++;
      if (we_no_tack - n0 != 0) begin errors++; $display("FAIL wait_we_without_tack: got %0d, required 0", we_no_tack - n0); end
   endtask

   task automatic test_reset_abort();
      int w0, n, cyc;
      for (int k = 0; k < 8; k++) preload_l2(10'h300 + 10'(k), pat(8'hD0, k));
      preload_l1(10'h082, '0);
      preload_l2(10'h310, pat(8'hE0, 0));
      settle();
      w0 = l1_we_cnt;
      issue_cmd(1'b0, 10'h300, 10'h080, 11'd8);
      n = 0;
      while (l1_we_cnt - w0 < 2 && n < 50) begin
         @(negedge clock);
         #1;
         n++;
      end
      checks++;
      if (l1_we_cnt - w0 < 2) begin errors++; $display("FAIL abort_progress: %0d writes, required 2", l1_we_cnt - w0); end
      // second write lands on this edge; pull reset before the third
      @(posedge clock);
      #2;
      nreset = 1'b0;
      #1;
      checks += 4;
      if (trq !== 1'b0)   begin errors++; $display("FAIL abort_trq: got %b, required 0", trq); end
      if (l1_we !== 1'b0) begin errors++; $display("FAIL abort_l1_we: got %b, required 0", l1_we); end
      if (l2_we !== 1'b0) begin errors++; $display("FAIL abort_l2_we: got %b, required 0", l2_we); end
      if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
      @(negedge clock);
      @(negedge clock);
      nreset = 1'b1;
      @(negedge clock);
      checks += 3;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, required 1", cmd_ready); end
      if (l1_mem[10'h081] !== pat(8'hD0, 1)) begin
         errors++; $display("FAIL abort_word1: got %h, required %h", l1_mem[10'h081], pat(8'hD0, 1));
      end
      if (l1_mem[10'h082] !== '0) begin errors++; $display("FAIL abort_word2: got %h, required 0", l1_mem[10'h082]); end
      issue_cmd(1'b0, 10'h310, 10'h090, 11'd1);
      wait_done(20, "abort_new", cyc);
      settle();
      checks++;
      if (l1_mem[10'h090] !== pat(8'hE0, 0)) begin
         errors++; $display("FAIL abort_new_data: got %h, required %h", l1_mem[10'h090], pat(8'hE0, 0));
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      preload_l2(10'h020, pat(8'hF0, 0));
      preload_l2(10'h021, pat(8'hF0, 1));
      settle();
      // first command: load L2[0x20..0x21] -> L1[0xA0..0xA1]
      @(negedge clock);
      cmd_dir = 1'b0; cmd_l2_addr = 10'h020; cmd_l1_addr = 10'h0A0; cmd_len = 11'd2;
      cmd_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      // second command, valid held: store L1[0xA0..0xA1] -> L2[0x40..0x41]
      cmd_dir = 1'b1; cmd_l2_addr = 10'h040; cmd_l1_addr = 10'h0A0; cmd_len = 11'd2;
      wait_done(30, "b2b_first", cyc);
      @(negedge clock);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %b, required 1", cmd_ready); end
      @(posedge clock);
      @(negedge clock);
      cmd_valid = 1'b0;
      checks++;
      if (trq !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: trq=%b, required 1", trq); end
      wait_done(30, "b2b_second", cyc);
      settle();
      checks++;
      if (last_gap != 2) begin errors++; $display("FAIL b2b_trq_gap: got %0d, required 2", last_gap); end
      for (int k = 0; k < 2; k++) begin
         checks += 2;
         if (l1_mem[10'h0A0 + 10'(k)] !== pat(8'hF0, k)) begin
            errors++;
            $display("FAIL b2b_l1_data[%0d]: got %h, required %h", k, l1_mem[10'h0A0 + 10'(k)], pat(8'hF0, k));
         end
         if (l2_mem[10'h040 + 10'(k)] !== pat(8'hF0, k)) begin
            errors++;
            $display("FAIL b2b_l2_data[%0d]: got %h, required %h", k, l2_mem[10'h040 + 10'(k)], pat(8'hF0, k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store_wrap();
      test_zero_len();
      test_grant_wait();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
